// File: rtl/mont_multi_core_ctrl.sv
// Command-driven controller for NUM_CORES Montgomery multiplier cores: loads operands
// from DMA data, launches a masked subset of cores, collects results, reports status.

module mont_lane #(
   parameter int DATA_W = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_a,
   input  logic              ld_b,
   input  logic              ld_m,
   input  logic              cap,
   input  logic              clr,
   input  logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] result_in,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] m,
   output logic [DATA_W-1:0] res,
   output logic              flag
);
   always_ff @(posedge clk) begin
      if (reset) begin
         a    <= '0;
         b    <= '0;
         m    <= '0;
         res  <= '0;
         flag <= 1'b0;
      end else begin
         if (ld_a) a <= din;
         if (ld_b) b <= din;
         if (ld_m) m <= din;
         if (cap)  res <= result_in;
         // Sticky done: cleared at launch, set once the core reports completion.
         if (clr)      flag <= 1'b0;
         else if (cap) flag <= 1'b1;
      end
   end
endmodule

module mont_multi_core_ctrl #(
   parameter int DATA_W         = 512,
   parameter int NUM_CORES      = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CORES*DATA_W-1:0]   bram_din,
   input  logic                          bram_din_valid,
   output logic [NUM_CORES*DATA_W-1:0]   bram_dout,
   output logic [NUM_CORES-1:0]          bram_dout_valid,
   input  logic                          bram_dout_read,
   input  logic [31:0]                   port1_din,
   input  logic                          port1_valid,
   output logic                          port1_read,
   output logic [31:0]                   port2_dout,
   output logic                          port2_valid,
   input  logic                          port2_read,
   output logic [NUM_CORES-1:0]          core_start,
   output logic [NUM_CORES*DATA_W-1:0]   core_a,
   output logic [NUM_CORES*DATA_W-1:0]   core_b,
   output logic [NUM_CORES*DATA_W-1:0]   core_m,
   input  logic [NUM_CORES*DATA_W-1:0]   core_result,
   input  logic [NUM_CORES-1:0]          core_done,
   output logic [3:0]                    leds
);
   typedef enum logic [2:0] {
      IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, WAIT = 3'd3, WRITE = 3'd4, DONE = 3'd5
   } state_t;

   localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);

   state_t               state;
   logic [3:0]           opc;
   logic [NUM_CORES-1:0] sel;
   logic [1:0]           status;
   logic [31:0]          cnt;

   logic [NUM_CORES-1:0] cmd_mask, eff_mask;
   logic [NUM_CORES-1:0] ld_a, ld_b, ld_m, cap, flag;
   logic                 ld_go, clr, done_all;
   logic                 unused_bits;

   assign cmd_mask    = port1_din[8 +: NUM_CORES];
   assign eff_mask    = (cmd_mask == '0) ? '1 : cmd_mask;
   assign unused_bits = &{1'b0, port1_din[31:4]};

   assign ld_go    = (state == LOAD) && bram_din_valid;
   assign ld_a     = (ld_go && opc == 4'd1) ? sel : '0;
   assign ld_b     = (ld_go && opc == 4'd2) ? sel : '0;
   assign ld_m     = (ld_go && opc == 4'd3) ? sel : '0;
   assign cap      = (state == WAIT) ? (sel & core_done) : '0;
   assign clr      = (state == START);
   // Completion includes cores finishing in this very cycle.
   assign done_all = (((flag | cap) & sel) == sel);

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
      mont_lane #(.DATA_W(DATA_W)) u_lane (
         .clk       (clk),
         .reset     (reset),
         .ld_a      (ld_a[i]),
         .ld_b      (ld_b[i]),
         .ld_m      (ld_m[i]),
         .cap       (cap[i]),
         .clr       (clr),
         .din       (bram_din[i*DATA_W +: DATA_W]),
         .result_in (core_result[i*DATA_W +: DATA_W]),
         .a         (core_a[i*DATA_W +: DATA_W]),
         .b         (core_b[i*DATA_W +: DATA_W]),
         .m         (core_m[i*DATA_W +: DATA_W]),
         .res       (bram_dout[i*DATA_W +: DATA_W]),
         .flag      (flag[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         opc        <= '0;
         sel        <= '0;
         status     <= '0;
         cnt        <= '0;
         core_start <= '0;
         port1_read <= 1'b0;
      end else begin
         port1_read <= 1'b0;
         core_start <= '0;
         case (state)
            IDLE: if (port1_valid) begin
               opc        <= port1_din[3:0];
               sel        <= eff_mask;
               port1_read <= 1'b1;
               case (port1_din[3:0])
                  4'd1, 4'd2, 4'd3: state <= LOAD;
                  4'd4:             state <= START;
                  4'd5:             state <= WRITE;
                  default: begin
                     state  <= DONE;
                     status <= 2'd1;
                  end
               endcase
            end
            LOAD: if (bram_din_valid) begin
               state  <= DONE;
               status <= 2'd0;
            end
            START: begin
               core_start <= sel;
               cnt        <= '0;
               state      <= WAIT;
            end
            WAIT: if (done_all) begin
               state  <= DONE;
               status <= 2'd0;
            end else begin
               cnt <= cnt + 32'd1;
               if (TO != '0 && cnt == TO - 32'd1) begin
                  state  <= DONE;
                  status <= 2'd2;
               end
            end
            WRITE: if (bram_dout_read) begin
               state  <= DONE;
               status <= 2'd0;
            end
            DONE: if (port2_read) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign port2_valid     = (state == DONE);
   assign port2_dout      = (state == DONE) ? {30'd0, status} : 32'd0;
   assign bram_dout_valid = (state == WRITE) ? sel : '0;
   assign leds            = {1'b0, state};
endmodule
